// File: rtl/led_pkg.sv
// Shared constants for the LED fade block: default level width, peak level and channel count.
package led_pkg;

  localparam int unsigned LVL_W   = 4;
  localparam int unsigned LVL_MAX = (1 << LVL_W) - 1;
  localparam int unsigned N_LED   = 8;

endpackage

// File: rtl/led_fade_ch.sv
// One LED channel: brightness level register plus registered PWM comparator.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   led_in      - channel on/off request from the chaser
//   fade_en     - 1 = PWM output from level, 0 = registered pass-through
//   decay_tick  - shared one-cycle decay strobe
//   pcnt        - shared PWM phase counter
//   led_out     - registered LED drive
//   mid_c       - combinational: next level is strictly between 0 and peak
module led_fade_ch
  import led_pkg::*;
#(
  parameter int unsigned LW = LVL_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          led_in,
  input  logic          fade_en,
  input  logic          decay_tick,
  input  logic [LW-1:0] pcnt,
  output logic          led_out,
  output logic          mid_c
);

  localparam logic [LW-1:0] PEAK = {LW{1'b1}};

  logic [LW-1:0] level;
  logic [LW-1:0] level_nxt;

  // Retrigger beats decay; decay saturates at zero.
  always_comb begin
    level_nxt = level;
    if (led_in) begin
      level_nxt = PEAK;
    end else if (decay_tick && (level != '0)) begin
      level_nxt = level - LW'(1);
    end
  end

  assign mid_c = (level_nxt != '0) && (level_nxt != PEAK);

  // Compare against the level being loaded so a rising led_in shows after one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      level   <= '0;
      led_out <= 1'b0;
    end else begin
      level   <= level_nxt;
      led_out <= fade_en ? (level_nxt > pcnt) : led_in;
    end
  end

endmodule

// File: rtl/led_fade_pwm.sv
// Trailing-fade PWM stage for an 8-LED chaser: shared decay and PWM counters,
// one level/comparator channel per LED.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   led_in   - LED on/off pattern from the chaser
//   fade_en  - 1 = trailing fade, 0 = direct pass-through (1-cycle latency)
//   led_out  - registered PWM LED drive
//   fading   - registered: some channel level is between 1 and peak-1
module led_fade_pwm #(
  parameter int unsigned DECAY_DIV = 750_000,
  parameter int unsigned LVL_W     = led_pkg::LVL_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [led_pkg::N_LED-1:0] led_in,
  input  logic                      fade_en,
  output logic [led_pkg::N_LED-1:0] led_out,
  output logic                      fading
);

  import led_pkg::*;

  localparam int unsigned LVL_PEAK = (1 << LVL_W) - 1;
  localparam int unsigned DCNT_W   = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  logic [DCNT_W-1:0] dcnt;
  logic [LVL_W-1:0]  pcnt;
  logic              decay_tick_c;
  logic [N_LED-1:0]  mid_c;

  assign decay_tick_c = (dcnt == DCNT_W'(DECAY_DIV - 1));

  // Free-running decay divider and PWM phase counter, shared by all channels.
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt <= '0;
      pcnt <= '0;
    end else begin
      dcnt <= decay_tick_c ? '0 : dcnt + DCNT_W'(1);
      pcnt <= (pcnt == LVL_W'(LVL_PEAK - 1)) ? '0 : pcnt + LVL_W'(1);
    end
  end

  for (genvar i = 0; i < N_LED; i++) begin : g_ch
    led_fade_ch #(
      .LW (LVL_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .led_in     (led_in[i]),
      .fade_en    (fade_en),
      .decay_tick (decay_tick_c),
      .pcnt       (pcnt),
      .led_out    (led_out[i]),
      .mid_c      (mid_c[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fading <= 1'b0;
    end else begin
      fading <= |mid_c;
    end
  end

endmodule

// File: tb/tb_led_fade_pwm.sv
module tb_led_fade_pwm;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] led_in;
  logic       fade_en;
  logic [7:0] led_out;
  logic       fading;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  led_fade_pwm #(
    .DECAY_DIV (4),
    .LVL_W     (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .led_in  (led_in),
    .fade_en (fade_en),
    .led_out (led_out),
    .fading  (fading)
  );

  always #5 clk = ~clk;

  // Advance one clock; sample point is 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Level expected in cycle k after a one-cycle pulse in cycle s (decay tick ends cycles 3,7,11,..).
  function automatic int exp_level(input int s, input int k);
    int n = 0;
    for (int t = s + 1; t <= k - 1; t++) begin
      if ((t % 4) == 3) n++;
    end
    return (15 - n < 0) ? 0 : 15 - n;
  endfunction

  function automatic logic exp_pwm(input int s, input int k);
    return exp_level(s, k) > ((k - 1) % 15);
  endfunction

  function automatic logic exp_mid(input int s, input int k);
    int l;
    l = exp_level(s, k);
    return (l >= 1) && (l <= 14);
  endfunction

  // Reset for three cycles; afterwards cyc=0 is the first post-reset cycle.
  task automatic do_reset();
    rst    = 1'b1;
    led_in = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    led_in  = 8'hFF;
    fade_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (led_out !== 8'h00) begin
        failures++;
        $display("FAIL reset_led_out cycle %0d: got %h want 00", i, led_out);
      end
      checks++;
      if (fading !== 1'b0) begin
        failures++;
        $display("FAIL reset_fading cycle %0d: got %b want 0", i, fading);
      end
    end
    rst = 1'b0;
    cyc = 0;
    tick();
    checks++;
    if (led_out !== 8'hFF) begin
      failures++;
      $display("FAIL reset_release: got %h want FF", led_out);
    end
    led_in = 8'h00;
  endtask

  task automatic test_held();
    do_reset();
    fade_en = 1'b1;
    led_in  = 8'h01;
    for (int k = 1; k <= 40; k++) begin
      tick();
      checks++;
      if (led_out !== 8'h01) begin
        failures++;
        $display("FAIL held_led_out k=%0d: got %h want 01", k, led_out);
      end
      checks++;
      if (fading !== 1'b0) begin
        failures++;
        $display("FAIL held_fading k=%0d: got %b want 0", k, fading);
      end
    end
    led_in = 8'h00;
  endtask

  task automatic test_decay();
    do_reset();
    fade_en = 1'b1;
    led_in  = 8'h01;
    tick();
    led_in = 8'h00;
    for (int k = 1; k <= 80; k++) begin
      checks++;
      if (led_out !== {7'b0, exp_pwm(0, k)}) begin
        failures++;
        $display("FAIL decay_led_out k=%0d: got %h want %h", k, led_out, {7'b0, exp_pwm(0, k)});
      end
      checks++;
      if (fading !== exp_mid(0, k)) begin
        failures++;
        $display("FAIL decay_fading k=%0d: got %b want %b", k, fading, exp_mid(0, k));
      end
      tick();
    end
  endtask

  task automatic test_coincident();
    do_reset();
    fade_en = 1'b1;
    led_in  = 8'h08;
    tick();
    led_in = 8'h00;
    while (cyc < 27) tick();
    // cycle 27: level is 9 and decay_tick is active
    led_in = 8'h08;
    tick();
    led_in = 8'h00;
    for (int k = 28; k <= 45; k++) begin
      checks++;
      if (led_out !== {4'b0, exp_pwm(27, k), 3'b0}) begin
        failures++;
        $display("FAIL coincident_led_out k=%0d: got %h want %h", k, led_out, {4'b0, exp_pwm(27, k), 3'b0});
      end
      checks++;
      if (fading !== exp_mid(27, k)) begin
        failures++;
        $display("FAIL coincident_fading k=%0d: got %b want %b", k, fading, exp_mid(27, k));
      end
      tick();
    end
  endtask

  task automatic test_bypass();
    logic [7:0] pat;
    do_reset();
    fade_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pat    = 8'h01 << i;
      led_in = pat;
      tick();
      checks++;
      if (led_out !== pat) begin
        failures++;
        $display("FAIL bypass_step%0d: got %h want %h", i, led_out, pat);
      end
    end
    led_in = 8'h00;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (led_out !== 8'h00) begin
        failures++;
        $display("FAIL bypass_release k=%0d: got %h want 00", k, led_out);
      end
    end
    fade_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    fade_en = 1'b1;
    led_in  = 8'h01;
    tick();
    led_in = 8'h00;
    while (cyc < 29) tick();
    // level[0] is 8 here
    checks++;
    if (fading !== 1'b1) begin
      failures++;
      $display("FAIL midreset_pre_fading: got %b want 1", fading);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cyc = 0;
    checks++;
    if (led_out !== 8'h00) begin
      failures++;
      $display("FAIL midreset_led_out: got %h want 00", led_out);
    end
    checks++;
    if (fading !== 1'b0) begin
      failures++;
      $display("FAIL midreset_fading: got %b want 0", fading);
    end
    while (cyc < 5) begin
      tick();
      checks++;
      if (led_out !== 8'h00) begin
        failures++;
        $display("FAIL midreset_level_cleared k=%0d: got %h want 00", cyc, led_out);
      end
    end
    // retrigger in cycle 5 to observe pcnt/dcnt phase after reset
    led_in = 8'h01;
    tick();
    led_in = 8'h00;
    for (int k = 6; k <= 40; k++) begin
      checks++;
      if (led_out !== {7'b0, exp_pwm(5, k)}) begin
        failures++;
        $display("FAIL midreset_phase k=%0d: got %h want %h", k, led_out, {7'b0, exp_pwm(5, k)});
      end
      tick();
    end
  endtask

  initial begin
    rst     = 1'b1;
    led_in  = 8'h00;
    fade_en = 1'b1;
    test_reset();
    test_held();
    test_decay();
    test_coincident();
    test_bypass();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_fade_pwm.md
LED_FADE_PWM -- requirements
Module: led_fade_pwm

Interface
REQ-001 SHALL have parameter DECAY_DIV, default 750_000, meaning clk cycles per brightness decay step (62.5 ms at 12 MHz); legal range 1 to 2^24.
REQ-002 SHALL have parameter LVL_W, default 4, meaning the brightness level width; maximum level LVL_MAX = 2^LVL_W - 1.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1 bit: system clock (12 MHz on the target board).
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port led_in, input, 8 bits: LED on/off pattern from the upstream chaser stage.
REQ-007 SHALL have port fade_en, input, 1 bit: 1 = trailing fade enabled; 0 = direct pass-through.
REQ-008 SHALL have port led_out, output, 8 bits: PWM-modulated LED drive, registered.
REQ-009 SHALL have port fading, output, 1 bit: high while any channel level is between 1 and LVL_MAX-1, registered.

Function
REQ-010 SHALL keep one LVL_W-bit level register per LED channel i (0..7).
REQ-011 SHALL run decay counter dcnt from 0 to DECAY_DIV-1 and wrap; decay_tick is high in the cycle dcnt == DECAY_DIV-1; DECAY_DIV=1 gives a tick every cycle.
REQ-012 SHALL run free-running PWM counter pcnt from 0 to LVL_MAX-1 and wrap, giving a period of LVL_MAX cycles.
REQ-013 SHALL update each channel with priority: (a) led_in[i]=1 sets level to LVL_MAX; (b) otherwise decay_tick=1 and level>0 decrements level by 1; (c) otherwise level holds.
REQ-014 SHALL let led_in[i]=1 win over a coincident decay_tick: level becomes LVL_MAX, not LVL_MAX-1.
REQ-015 SHALL keep a level of 0 at 0 on decay_tick; it never wraps to LVL_MAX.
REQ-016 SHALL, with fade_en=1, register led_out[i] as (level[i] > pcnt), using the level and pcnt values of the same cycle.
REQ-017 SHALL therefore give led_out[i] a duty of exactly level/LVL_MAX per PWM period: LVL_MAX is constant high, 0 is constant low.
REQ-018 SHALL, with fade_en=0, set led_out <= led_in (1-cycle latency); levels still update per REQ-013.
REQ-019 SHALL apply a change of fade_en on the next clock edge with no glitch beyond one PWM period.
REQ-020 SHALL have a latency from a led_in[i] rising edge to led_out[i]=1 of exactly 1 cycle, in both modes.
REQ-021 SHALL take exactly LVL_MAX decay ticks for a full decay after led_in[i] falls; with the defaults this is 15 x 62.5 ms = 0.94 s.
REQ-022 SHALL keep dcnt and pcnt free-running and independent of led_in.

Reset
REQ-023 SHALL, while rst=1 at a clock edge, set all levels, dcnt and pcnt to 0, led_out to 8'h00 and fading to 0.
REQ-024 SHALL abort any fade in progress on reset mid-operation; no level is retained.
REQ-025 SHALL require no initial values beyond reset for correct operation.

Structure
REQ-026 SHALL place LVL_W, LVL_MAX and the LED channel count (8) in shared package led_pkg.
REQ-027 SHALL implement the per-channel level register and comparator as sub-module led_fade_ch, instantiated 8 times.
REQ-028 SHALL have the decay and PWM counters live once in the top level and be shared by all channels.

Verification
All scenarios use DECAY_DIV=4 and LVL_W=4.
REQ-029 SHALL cover reset: rst=1 for 3 cycles with led_in=8'hFF -> led_out=8'h00 and fading=0 throughout; 1 cycle after release, led_out=8'hFF.
REQ-030 SHALL cover a held input: led_in=8'h01 held with fade_en=1 -> led_out[0]=1 every cycle from cycle 1 and led_out[7:1]=0; fading=0.
REQ-031 SHALL cover a full decay: led_in=8'h01 for 1 cycle then 8'h00 -> level[0] steps 15 to 0 over 15 ticks (60 cycles); duty per 15-cycle period equals the level; after that led_out[0]=0 permanently; fading drops after the last step.
REQ-032 SHALL cover a coincident event: led_in[3] reasserted in the same cycle as decay_tick at level 9 -> level[3]=15, not 8.
REQ-033 SHALL cover bypass: fade_en=0 with led_in stepping 01, 02, 04, ..., 80 -> led_out equals led_in delayed by 1 cycle, with no PWM.
REQ-034 SHALL cover reset mid-fade: rst pulsed for 1 cycle at level[0]=8 -> next cycle led_out=8'h00, all levels 0 and pcnt restarts at 0.
